// File: rtl/ddr3_status_pkg.sv
// Shared types and constants for the DDR3 calibration status poller.
// Bit positions follow the layout of the DDR3 status PIO.
package ddr3_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP
    } pollState_e;

    localparam int INIT_DONE_BIT = 0;
    localparam int CAL_OK_BIT    = 1;
    localparam int CAL_FAIL_BIT  = 2;
    localparam int PLL_LOCK_BIT  = 3;

endpackage

// File: rtl/status_event_latch.sv
// Holds the last captured status word, detects changes, keeps the sticky
// calibration outcome flags and drives the acknowledgeable level interrupt.
module status_event_latch
    import ddr3_status_pkg::*;
#(
    parameter int STATUS_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                capture_i,
    input  logic [STATUS_W-1:0] rdStatus_i,
    input  logic                timeoutReached_i,
    input  logic                irqAck_i,
    output logic [STATUS_W-1:0] status_o,
    output logic                statusValid_o,
    output logic                changePulse_o,
    output logic                calDone_o,
    output logic                calFail_o,
    output logic                timeout_o,
    output logic                anyFlag_o,
    output logic                irq_o
);

    logic [STATUS_W-1:0] status_q, status_d;
    logic                statusValid_q, statusValid_d;
    logic                changePulse_q, changePulse_d;
    logic                calDone_q, calDone_d;
    logic                calFail_q, calFail_d;
    logic                timeout_q, timeout_d;
    logic                newFlag_q, newFlag_d;
    logic                irq_q, irq_d;
    logic                doneNow, failNow, anyFlag, timeoutNow;

    // A failure bit in the same word as cal_success overrides it.
    always_comb begin
        status_d      = status_q;
        statusValid_d = statusValid_q;
        changePulse_d = 1'b0;
        calDone_d     = calDone_q;
        calFail_d     = calFail_q;
        timeout_d     = timeout_q;
        newFlag_d     = 1'b0;

        failNow    = rdStatus_i[CAL_FAIL_BIT];
        doneNow    = rdStatus_i[CAL_OK_BIT] & rdStatus_i[INIT_DONE_BIT] & ~failNow;
        anyFlag    = calDone_q | calFail_q | timeout_q;
        timeoutNow = timeoutReached_i & ~anyFlag & ~doneNow & ~failNow;

        if (capture_i) begin
            status_d      = rdStatus_i;
            statusValid_d = 1'b1;
            changePulse_d = statusValid_q & (rdStatus_i != status_q);
            calDone_d     = calDone_q | doneNow;
            calFail_d     = calFail_q | failNow;
            timeout_d     = timeout_q | timeoutNow;
            newFlag_d     = (doneNow & ~calDone_q) | (failNow & ~calFail_q) | timeoutNow;
        end

        irq_d = changePulse_q | newFlag_q | (irq_q & ~irqAck_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q      <= '0;
            statusValid_q <= 1'b0;
            changePulse_q <= 1'b0;
            calDone_q     <= 1'b0;
            calFail_q     <= 1'b0;
            timeout_q     <= 1'b0;
            newFlag_q     <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            status_q      <= status_d;
            statusValid_q <= statusValid_d;
            changePulse_q <= changePulse_d;
            calDone_q     <= calDone_d;
            calFail_q     <= calFail_d;
            timeout_q     <= timeout_d;
            newFlag_q     <= newFlag_d;
            irq_q         <= irq_d;
        end
    end

    assign status_o      = status_q;
    assign statusValid_o = statusValid_q;
    assign changePulse_o = changePulse_q;
    assign calDone_o     = calDone_q;
    assign calFail_o     = calFail_q;
    assign timeout_o     = timeout_q;
    assign anyFlag_o     = anyFlag;
    assign irq_o         = irq_q;

endmodule

// File: rtl/ddr3_status_poller.sv
// Avalon-MM master that periodically reads the DDR3 status PIO and reports
// calibration outcome to fabric logic without processor involvement.
module ddr3_status_poller
    import ddr3_status_pkg::*;
#(
    parameter int POLL_INTERVAL = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int TIMEOUT_POLLS = 4096,
    parameter int STATUS_W      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    output logic [1:0]          avm_address_o,
    output logic                avm_read_o,
    input  logic                avm_waitrequest_i,
    input  logic [31:0]         avm_readdata_i,
    output logic [STATUS_W-1:0] status_o,
    output logic                status_valid_o,
    output logic                change_pulse_o,
    output logic                cal_done_o,
    output logic                cal_fail_o,
    output logic                timeout_o,
    output logic                irq_o,
    input  logic                irq_ack_i
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int GAP_W = $clog2(POLL_INTERVAL + 1);
    localparam int CNT_W = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_POLLS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_POLLS - 1);

    pollState_e          state_q, state_d;
    logic [LAT_W-1:0]    latCnt_q, latCnt_d;
    logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
    logic [CNT_W-1:0]    pollCnt_q, pollCnt_d;
    logic [STATUS_W-1:0] rdData_q, rdData_d;
    logic                capture;
    logic                anyFlag;
    logic                unusedReaddata;

    assign unusedReaddata = ^avm_readdata_i[31:STATUS_W];

    // Once a read is accepted it always runs to CAPTURE; enable is only
    // honoured in IDLE and GAP so the slave handshake is never cut short.
    always_comb begin
        state_d   = state_q;
        latCnt_d  = latCnt_q;
        gapCnt_d  = gapCnt_q;
        pollCnt_d = pollCnt_q;
        rdData_d  = rdData_q;
        capture   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gapCnt_d = '0;
                if (enable_i) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!avm_waitrequest_i) begin
                    latCnt_d = LAT_W'(1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (latCnt_q == LAT_LAST) begin
                    rdData_d = avm_readdata_i[STATUS_W-1:0];
                    state_d  = ST_CAPTURE;
                end else begin
                    latCnt_d = latCnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture  = 1'b1;
                gapCnt_d = '0;
                if (!anyFlag && pollCnt_q != CNT_MAX) pollCnt_d = pollCnt_q + 1'b1;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                if (!enable_i) begin
                    gapCnt_d = '0;
                    state_d  = ST_IDLE;
                end else if (gapCnt_q == GAP_LAST) begin
                    state_d  = ST_REQ;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            latCnt_q  <= '0;
            gapCnt_q  <= '0;
            pollCnt_q <= '0;
            rdData_q  <= '0;
        end else begin
            state_q   <= state_d;
            latCnt_q  <= latCnt_d;
            gapCnt_q  <= gapCnt_d;
            pollCnt_q <= pollCnt_d;
            rdData_q  <= rdData_d;
        end
    end

    assign avm_read_o    = (state_q == ST_REQ);
    assign avm_address_o = 2'd0;

    status_event_latch #(
        .STATUS_W(STATUS_W)
    ) u_eventLatch (
        .clk             (clk),
        .reset_n         (reset_n),
        .capture_i       (capture),
        .rdStatus_i      (rdData_q),
        .timeoutReached_i(pollCnt_q >= CNT_LAST),
        .irqAck_i        (irq_ack_i),
        .status_o        (status_o),
        .statusValid_o   (status_valid_o),
        .changePulse_o   (change_pulse_o),
        .calDone_o       (cal_done_o),
        .calFail_o       (cal_fail_o),
        .timeout_o       (timeout_o),
        .anyFlag_o       (anyFlag),
        .irq_o           (irq_o)
    );

endmodule

// File: tb/tb_ddr3_status_poller.sv
// Self-checking bench for ddr3_status_poller: a scripted Avalon slave feeds
// directed and random status words, and a poll-level model predicts outputs.
module tb_ddr3_status_poller;

    localparam int PI = 4;
    localparam int RL = 2;
    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  avmAddress;
    logic        avmRead;
    logic        avmWaitrequest = 1'b0;
    logic [31:0] avmReaddata = 32'd0;
    logic [3:0]  status;
    logic        statusValid, changePulse, calDone, calFail, timeoutFlag, irq;
    logic        irqAck = 1'b0;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // Poll-level reference state
    logic [3:0] mPrev;
    bit mValid, mDone, mFail, mTo, mIrq;
    int mPolls;
    bit periodKnown;
    int lastReq, lastStall;

    ddr3_status_poller #(
        .POLL_INTERVAL(PI),
        .READ_LATENCY (RL),
        .TIMEOUT_POLLS(TO),
        .STATUS_W     (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable_i         (enable),
        .avm_address_o    (avmAddress),
        .avm_read_o       (avmRead),
        .avm_waitrequest_i(avmWaitrequest),
        .avm_readdata_i   (avmReaddata),
        .status_o         (status),
        .status_valid_o   (statusValid),
        .change_pulse_o   (changePulse),
        .cal_done_o       (calDone),
        .cal_fail_o       (calFail),
        .timeout_o        (timeoutFlag),
        .irq_o            (irq),
        .irq_ack_i        (irqAck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        mPrev = 4'd0; mValid = 0; mDone = 0; mFail = 0; mTo = 0; mIrq = 0;
        mPolls = 0; periodKnown = 0;
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, ".read"}, avmRead, 0);
        checkOutput({tag, ".addr"}, avmAddress, 0);
        checkOutput({tag, ".status"}, status, 0);
        checkOutput({tag, ".valid"}, statusValid, 0);
        checkOutput({tag, ".flags"}, {changePulse, calDone, calFail, timeoutFlag, irq}, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; irqAck = 1'b0; avmWaitrequest = 1'b0;
        #1 checkAllClear("reset");
        @(negedge clk);
        reset_n = 1'b1;
        resetModel();
    endtask

    task automatic waitReq(output bit got);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (avmRead) begin
                got = 1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!got) checkOutput("reqTimeout", 0, 1);
    endtask

    task automatic checkIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idleNoRead", avmRead, 0);
        end
    endtask

    // One full poll: stall the request, return stat after RL cycles, then
    // check the captured result and the interrupt over the next two cycles.
    task automatic applyStimulus(input logic [3:0] stat, input int stall,
                                 input bit ackC, input bit ackD, input bit dropEn);
        logic [31:0] r;
        bit got, chg, dn, fl, tn, ev, expIrq;
        waitReq(got);
        if (!got) return;
        if (periodKnown) checkOutput("period", cyc - lastReq, lastStall + 1 + RL + 1 + PI);
        lastReq = cyc; lastStall = stall; periodKnown = 1;
        for (int k = 0; k < stall; k++) begin
            checkOutput("readHeld", avmRead, 1);
            checkOutput("addrHeld", avmAddress, 0);
            avmWaitrequest = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("readHeld", avmRead, 1);
        checkOutput("addrHeld", avmAddress, 0);
        avmWaitrequest = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= RL; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("readDrop", avmRead, 0);
            if (k == 0 && dropEn) enable = 1'b0;
            r = $urandom();
            if (k == RL - 1) r[3:0] = stat;
            avmReaddata = r;
            avmWaitrequest = 1'($urandom_range(0, 1));
            @(posedge clk);
        end

        chg = mValid && (stat != mPrev);
        dn  = stat[1] && stat[0] && !stat[2];
        fl  = stat[2];
        tn  = 0;
        if (!(mDone || mFail || mTo) && !dn && !fl) begin
            mPolls++;
            if (mPolls >= TO) tn = 1;
        end
        ev = chg || (dn && !mDone) || (fl && !mFail) || tn;
        mDone = mDone | dn; mFail = mFail | fl; mTo = mTo | tn;
        mPrev = stat; mValid = 1;

        @(negedge clk);
        checkOutput("status", status, stat);
        checkOutput("statusValid", statusValid, 1);
        checkOutput("changePulse", changePulse, chg);
        checkOutput("calDone", calDone, mDone);
        checkOutput("calFail", calFail, mFail);
        checkOutput("timeout", timeoutFlag, mTo);
        checkOutput("irqHold", irq, mIrq);
        irqAck = ackC;
        @(posedge clk);
        @(negedge clk);
        expIrq = ev || (mIrq && !ackC);
        checkOutput("irqSet", irq, expIrq);
        checkOutput("changeOneCycle", changePulse, 0);
        irqAck = ackD;
        @(posedge clk);
        @(negedge clk);
        mIrq = expIrq && !ackD;
        checkOutput("irqAck", irq, mIrq);
        irqAck = 1'b0;
    endtask

    initial begin
        bit got;
        int t;
        logic [3:0] s;
        resetModel();
        #3 checkAllClear("initReset");
        @(negedge clk);
        reset_n = 1'b1;

        // First capture: calibrated, no change pulse
        enable = 1'b1;
        applyStimulus(4'b1011, 0, 0, 0, 0);
        applyStimulus(4'b1011, 5, 0, 1, 0);

        // Single change on third capture; no timeout when success lands at the limit
        resetDut();
        enable = 1'b1;
        applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0011, 0, 0, 1, 0);

        // Failure wins over success, ack, then a change re-raises irq despite ack
        resetDut();
        enable = 1'b1;
        applyStimulus(4'b0111, 1, 0, 1, 0);
        applyStimulus(4'b0111, 0, 0, 0, 0);
        applyStimulus(4'b1111, 2, 1, 0, 0);
        applyStimulus(4'b1111, 0, 0, 1, 0);

        // Timeout after TO idle polls, then saturation
        resetDut();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, i % 2, 0, (i == 3), 0);

        // Enable dropped during WAIT: read finishes, then no more requests
        resetDut();
        enable = 1'b1;
        applyStimulus(4'b1001, 1, 0, 0, 1);
        checkIdle(12);

        // Enable dropped in GAP, then restart one cycle after re-enable
        @(negedge clk);
        enable = 1'b1; t = cyc; periodKnown = 0;
        applyStimulus(4'b1011, 0, 0, 1, 0);
        checkOutput("restartLat", lastReq - t, 1);
        enable = 1'b0;
        checkIdle(10);
        enable = 1'b1; t = cyc; periodKnown = 0;
        applyStimulus(4'b1011, 0, 0, 0, 0);
        checkOutput("restartLat", lastReq - t, 1);
        applyStimulus(4'b0011, 1, 0, 1, 0);

        // Randomised polls across several reset epochs
        for (int e = 0; e < 4; e++) begin
            resetDut();
            enable = 1'b1;
            for (int i = 0; i < 7; i++) begin
                s = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) != 0) s[2] = 1'b0;
                applyStimulus(s, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 0);
            end
        end

        // Reset asserted while the request is stalled drops avm_read at once
        avmWaitrequest = 1'b1;
        waitReq(got);
        if (got) begin
            reset_n = 1'b0;
            #1 checkAllClear("resetInReq");
            @(negedge clk);
            avmReaddata = 32'hFFFF_FFFF;
            avmWaitrequest = 1'b0;
            @(negedge clk);
            checkAllClear("resetHeld");
            reset_n = 1'b1;
            resetModel();
            applyStimulus(4'b0001, 0, 0, 0, 0);
            applyStimulus(4'b0101, 0, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ddr3_status_poller.md
Name: ddr3_status_poller

Overview:
Avalon-MM master that periodically reads the 4-bit DDR3 status PIO (word address 0, readdata registered, read latency 1) and presents debounced/decoded calibration status to fabric logic. Detects bit changes, flags calibration success, failure or timeout, and raises a level interrupt until acknowledged. Sits between the status PIO slave and reset-sequencing / LED logic, so no Nios involvement is needed at bring-up.

Parameters:
POLL_INTERVAL, 1024, idle clk cycles between read completions and next read request (min 1)
READ_LATENCY, 1, clk cycles from accepted read to valid readdata (1..4)
TIMEOUT_POLLS, 4096, completed polls without cal_success/cal_fail before timeout asserts (min 1)
STATUS_W, 4, status bits used from readdata[STATUS_W-1:0]

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
enable  in  1  polling enable; low parks FSM in IDLE after any in-flight read
avm_address  out  2  always 2'd0
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall; hold request while high
avm_readdata  in  32  read data
status  out  STATUS_W  last captured status
status_valid  out  1  high once first poll completes
change_pulse  out  1  one-cycle pulse when captured status differs from previous capture
cal_done  out  1  sticky: status[1] (cal_success) seen set with status[0] (init_done) set
cal_fail  out  1  sticky: status[2] seen set
timeout  out  1  sticky: TIMEOUT_POLLS polls elapsed with neither cal_done nor cal_fail
irq  out  1  level interrupt
irq_ack  in  1  clears irq

Behaviour:
- Reset: all outputs 0, avm_address 0, FSM IDLE, counters 0, previous-status register 0.
- Bits: status[0] init_done, [1] cal_success, [2] cal_fail, [3] pll_locked.
- States: IDLE -> REQ when enable=1. REQ: avm_read=1; stays while avm_waitrequest=1; on waitrequest=0 -> WAIT. WAIT: latency counter counts READ_LATENCY cycles; readdata sampled on the cycle counter reaches READ_LATENCY -> CAPTURE. CAPTURE (1 cycle): update status, flags, poll count -> GAP. GAP: interval counter counts POLL_INTERVAL cycles -> REQ if enable else IDLE.
- enable deasserted in REQ/WAIT: read completes normally (request never dropped mid-handshake), then IDLE. enable low in GAP: go IDLE immediately; interval counter cleared.
- Poll period with waitrequest=0: 1 + READ_LATENCY + 1 + POLL_INTERVAL cycles.
- change_pulse: in CAPTURE when status_valid=1 and new != previous; first capture never pulses.
- cal_done/cal_fail/timeout: set in CAPTURE, sticky until reset. cal_fail wins if bits 1 and 2 both set in same capture (cal_done not set). Timeout counter saturates; stops incrementing once any flag set. timeout not set if cal_done/cal_fail set in same capture that reaches count.
- irq: set on the cycle after any of cal_done, cal_fail, timeout, or change_pulse goes high (rising); cleared by irq_ack. Simultaneous new event and irq_ack: set wins.
- Async reset mid-read drops avm_read immediately; slave reply ignored.
- readdata bits above STATUS_W ignored.

Decomposition:
- Package ddr3_status_pkg: FSM state enum, status bit index constants (INIT_DONE_BIT=0, CAL_OK_BIT=1, CAL_FAIL_BIT=2, PLL_LOCK_BIT=3).
- One sub-module natural: status_event_latch (capture register, change detect, sticky flags, irq set/ack); FSM and counters in top.

Test Plan:
- Reset then enable=1, waitrequest=0, slave returns 4'b1011 after 1 cycle -> avm_read high 1 cycle, status=4'b1011 after CAPTURE, status_valid=1, cal_done=1, irq=1, no change_pulse.
- waitrequest held high 5 cycles -> avm_read stays high all 6 cycles, address 0; capture occurs READ_LATENCY cycles after release.
- Status sequence 0001,0001,0011 with POLL_INTERVAL=4 -> single change_pulse on third capture; read requests 7 cycles apart.
- Status returns 0111 -> cal_fail=1, cal_done=0; irq_ack then irq low; later change 0111->1111 re-raises irq.
- TIMEOUT_POLLS=3, status always 0001 -> timeout=1 at third CAPTURE, irq=1, counter saturates.
- enable dropped during WAIT -> read completes, status updated, FSM IDLE, no further avm_read; reset_n pulsed during REQ -> avm_read 0 immediately, all flags 0.
